step_sequencer: RTL and testbench

Command-driven step/direction generator that feeds the `step`, `dir` and `enable` inputs of the microstepper core from the system clock domain. Motion commands are accepted over a valid/ready handshake into a small FIFO. Each command is expanded into a train of fixed-width step pulses at a programmed period, with direction setup time enforced before any step that follows a direction change. A signed position counter tracks every emitted step edge.

---
 rtl/step_sequencer.sv | 179 +++++++++++++++++
 tb/tb_step_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - command FIFO driven step/dir pulse generator for the microstepper core
module step_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STEP_HIGH  = 8,
  parameter int DIR_SETUP  = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_dir,
  input  logic [WIDTH-1:0]              cmd_steps,
  input  logic [WIDTH-1:0]              cmd_period,
  input  logic                          abort,
  output logic                          step,
  output logic                          dir,
  output logic                          enable,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              position,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2 * STEP_HIGH);
  localparam logic [WIDTH-1:0] HIGH_LEN   = WIDTH'(STEP_HIGH);
  localparam logic [WIDTH-1:0] SETUP_LAST = WIDTH'(DIR_SETUP - 1);
  localparam logic [WIDTH-1:0] HIGH_LAST  = WIDTH'(STEP_HIGH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  cnt, cnt_n;
  logic [WIDTH-1:0]  rem, rem_n;
  logic [WIDTH-1:0]  low_len, low_len_n;
  logic              abort_pend, abort_pend_n;
  logic              dir_n, done_n, go_high;
  logic [WIDTH-1:0]  pos_n;

  logic [2*WIDTH:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [LW-1:0]     level;
  logic              fifo_full, fifo_empty, push, pop;
  logic              h_dir;
  logic [WIDTH-1:0]  h_steps, h_period, eff_period;

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign cmd_ready  = !fifo_full && !abort;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty && !abort;
  assign fifo_level = level;
  assign busy       = (state != IDLE) || !fifo_empty;

  assign {h_dir, h_steps, h_period} = mem[rd_ptr];
  assign eff_period = (h_period < MIN_PERIOD) ? MIN_PERIOD : h_period;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_dir, cmd_steps, cmd_period};
  end

  // abort drops everything queued by pulling the read pointer up to the write pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (abort) begin
        rd_ptr <= wr_ptr;
        level  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    rem_n        = rem;
    low_len_n    = low_len;
    abort_pend_n = abort_pend;
    dir_n        = dir;
    done_n       = 1'b0;
    pos_n        = position;
    go_high      = 1'b0;
    case (state)
      IDLE: begin
        abort_pend_n = 1'b0;
        if (pop) begin
          rem_n     = h_steps;
          low_len_n = eff_period - HIGH_LEN;
          if (h_steps == '0) begin
            done_n = 1'b1;
          end else if (h_dir != dir) begin
            dir_n   = h_dir;
            state_n = SETUP;
            cnt_n   = SETUP_LAST;
          end else begin
            go_high = 1'b1;
          end
        end
      end
      SETUP: begin
        if (abort)            state_n = IDLE;
        else if (cnt == '0)   go_high = 1'b1;
        else                  cnt_n = cnt - WIDTH'(1);
      end
      HIGH: begin
        if (abort) abort_pend_n = 1'b1;
        if (cnt == '0) begin
          if (abort || abort_pend) begin
            state_n      = IDLE;
            abort_pend_n = 1'b0;
          end else begin
            state_n = LOW;
            cnt_n   = low_len - WIDTH'(1);
          end
        end else begin
          cnt_n = cnt - WIDTH'(1);
        end
      end
      LOW: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          rem_n = rem - WIDTH'(1);
          if (rem == WIDTH'(1)) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            go_high = 1'b1;
          end
        end else begin
          cnt_n = cnt - WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // position counts each pulse as it is launched
    if (go_high) begin
      state_n = HIGH;
      cnt_n   = HIGH_LAST;
      pos_n   = dir ? position + WIDTH'(1) : position - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      low_len    <= '0;
      abort_pend <= 1'b0;
      step       <= 1'b0;
      dir        <= 1'b0;
      enable     <= 1'b0;
      done       <= 1'b0;
      position   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rem        <= rem_n;
      low_len    <= low_len_n;
      abort_pend <= abort_pend_n;
      step       <= (state == HIGH);
      dir        <= dir_n;
      enable     <= busy;
      done       <= done_n;
      position   <= pos_n;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - randomized scoreboard bench for step_sequencer
module tb_step_sequencer;

  localparam int DEPTH = 4;
  localparam int SH    = 8;
  localparam int DS    = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        step, dir, enable, busy, done;
  logic [15:0] position;
  logic [2:0]  fifo_level;

  step_sequencer #(.WIDTH(16), .FIFO_DEPTH(DEPTH), .STEP_HIGH(SH), .DIR_SETUP(DS)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .step(step), .dir(dir), .enable(enable), .busy(busy), .done(done),
    .position(position), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          d;
    logic [15:0] p;
  } rise_t;

  rise_t       rise_q[$];
  int          done_q[$];
  int          pop_q[$];
  int          free_edge = 0;
  bit          m_dir = 1'b0;
  logic [15:0] m_pos = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference timeline: a command popped at edge t fires its first rise at t+1 (+setup on a
  // direction change), further rises every P, and the sequencer can pop again P after the last rise
  task automatic model_accept(input int a, input bit d, input int steps, input int period);
    int p, pop_at, first, last;
    p = (period < 2 * SH) ? 2 * SH : period;
    pop_at = (a + 1 > free_edge) ? a + 1 : free_edge;
    pop_q.push_back(pop_at);
    if (steps == 0) begin
      done_q.push_back(pop_at);
      free_edge = pop_at + 1;
    end else begin
      first = pop_at + 1 + ((d != m_dir) ? DS : 0);
      m_dir = d;
      for (int k = 0; k < steps; k++) begin
        rise_t r;
        m_pos = d ? m_pos + 16'd1 : m_pos - 16'd1;
        r.at = first + k * p;
        r.d  = d;
        r.p  = m_pos;
        rise_q.push_back(r);
      end
      last = first + (steps - 1) * p;
      done_q.push_back(last - 1 + p);
      free_edge = last + p;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit d, input int steps, input int period, output int stalls);
    int lvl;
    stalls = 0;
    cmd_dir = d;
    cmd_steps = 16'(steps);
    cmd_period = 16'(period);
    cmd_valid = 1'b1;
    for (int w = 0; w < 2000; w++) begin
      @(negedge clk);
      while (pop_q.size() > 0 && pop_q[0] <= cyc) void'(pop_q.pop_front());
      lvl = pop_q.size();
      check(fifo_level == 3'(lvl), "fifo_level", fifo_level, lvl);
      check(cmd_ready == (lvl < DEPTH), "cmd_ready", cmd_ready, (lvl < DEPTH));
      if (cmd_ready) begin
        model_accept(cyc + 1, d, steps, period);
        tick();
        cmd_valid = 1'b0;
        return;
      end
      stalls++;
      tick();
    end
    check(1'b0, "send_timeout", stalls, 0);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int w = 0; w < 5000; w++) begin
      @(negedge clk);
      if (!busy && rise_q.size() == 0 && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "idle_timeout", ok, 1);
    tick();
  endtask

  task automatic wait_step_high();
    bit ok = 1'b0;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (step) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "step_timeout", ok, 1);
  endtask

  // monitor: pops the scoreboard on every step rise and done pulse
  bit    prev_step = 1'b0, prev_dir = 1'b0, prev_busy = 1'b0;
  int    hcnt = 0;
  rise_t exp_r;
  int    exp_d;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_step = 1'b0;
      prev_busy = 1'b0;
      hcnt = 0;
    end else begin
      check(enable == prev_busy, "enable", enable, prev_busy);
      if (step && !prev_step) begin
        if (rise_q.size() == 0) begin
          check(1'b0, "unexpected_step", cyc, -1);
        end else begin
          exp_r = rise_q.pop_front();
          check(cyc == exp_r.at, "rise_cycle", cyc, exp_r.at);
          check(dir == exp_r.d, "rise_dir", dir, exp_r.d);
          check(position == exp_r.p, "rise_position", position, exp_r.p);
        end
      end
      if (step && prev_step) check(dir == prev_dir, "dir_stable_high", dir, prev_dir);
      if (step) hcnt++;
      else if (prev_step) begin
        check(hcnt == SH, "step_width", hcnt, SH);
        hcnt = 0;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check(1'b0, "unexpected_done", cyc, -1);
        end else begin
          exp_d = done_q.pop_front();
          check(cyc == exp_d, "done_cycle", cyc, exp_d);
        end
      end
      prev_step = step;
      prev_dir  = dir;
      prev_busy = busy;
    end
  end

  initial begin
    int st;
    logic [15:0] p0;
    bit d0;

    repeat (3) @(negedge clk);
    check(step == 1'b0, "rst_step", step, 0);
    check(dir == 1'b0, "rst_dir", dir, 0);
    check(enable == 1'b0, "rst_enable", enable, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check(position == 16'd0, "rst_position", position, 0);
    check(fifo_level == 3'd0, "rst_level", fifo_level, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    tick();
    resetn = 1'b1;

    send(1'b1, 3, 40, st);
    wait_idle();
    check(position == 16'd3, "pos_after_first", position, 3);

    send(1'b1, 2, 5, st);
    wait_idle();

    send(1'b1, 2, 40, st);
    send(1'b0, 2, 40, st);
    send(1'b0, 0, 40, st);
    wait_idle();
    check(position == m_pos, "pos_after_chain", position, m_pos);

    for (int i = 0; i < 6; i++) send(1'b1, 1, 40, st);
    check(st > 0, "sixth_stalled", st, 1);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 60), st);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();
    check(position == m_pos, "pos_after_random", position, m_pos);

    // abort in the middle of the first pulse with three commands queued
    p0 = m_pos;
    d0 = m_dir;
    for (int i = 0; i < 4; i++) send(d0, 5, 40, st);
    wait_step_high();
    tick();
    abort = 1'b1;
    cmd_valid = 1'b1;
    rise_q.delete();
    done_q.delete();
    pop_q.delete();
    @(negedge clk);
    check(cmd_ready == 1'b0, "ready_during_abort", cmd_ready, 0);
    tick();
    @(negedge clk);
    check(fifo_level == 3'd0, "level_after_abort", fifo_level, 0);
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    m_pos = d0 ? p0 + 16'd1 : p0 - 16'd1;
    wait_idle();
    check(position == m_pos, "pos_after_abort", position, m_pos);
    check(dir == m_dir, "dir_after_abort", dir, m_dir);
    free_edge = cyc;

    // reset in the middle of a pulse, then wrap the position below zero
    send(1'b1, 2, 40, st);
    wait_step_high();
    tick();
    resetn = 1'b0;
    #1;
    check(step == 1'b0, "step_async_reset", step, 0);
    rise_q.delete();
    done_q.delete();
    pop_q.delete();
    m_pos = '0;
    m_dir = 1'b0;
    @(negedge clk);
    check(position == 16'd0, "pos_in_reset", position, 0);
    check(fifo_level == 3'd0, "level_in_reset", fifo_level, 0);
    tick();
    resetn = 1'b1;
    free_edge = 0;
    send(1'b0, 1, 20, st);
    wait_idle();
    check(position == 16'hFFFF, "pos_wrap", position, 16'hFFFF);

    check(rise_q.size() == 0, "rises_left", rise_q.size(), 0);
    check(done_q.size() == 0, "dones_left", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
